// File: rtl/burst_read_ctrl.sv
// burst_read_ctrl: SPI burst-read sequencer.
// Accepts a read command (0x03) and a 16-bit start address from the SPI slave.
// Then, for every tx slot the slave offers, it reads one byte from memory and
// hands it to the slave, advancing the address with wrap at ADDR_LIMIT.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cs                chip select (active-low, pre-synchronised)
//   i_rx_valid/i_rx_byte  received byte strobe and data
//   i_tx_ready          slave can take a tx byte
//   i_mem_data          memory read data (one cycle after o_addr_valid)
//   o_addr/o_addr_valid memory read address and strobe
//   o_tx_valid/o_tx_byte  byte to load into the slave
//   o_busy, o_err       status, protocol-error pulse
//   o_byte_count, o_crc bytes sent this transaction, running CRC-8
//
// Optional feature: define BURST_READ_CRC_EN to build the CRC-8 (poly 0x07)
// accumulator; otherwise o_crc is tied to zero.
module burst_read_ctrl #(
  parameter logic [15:0] ADDR_LIMIT = 16'h2803
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_mem_data,
  output logic [15:0] o_addr,
  output logic        o_addr_valid,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_byte,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_byte_count,
  output logic [7:0]  o_crc
);

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddrH, StAddrL, StFetch, StWait, StSend, StHold, StErr
  } state_e;

  state_e      r_state, w_state_next;
  logic        r_armed;  // cs has been seen high since reset
  logic [15:0] r_addr;
  logic [7:0]  r_tx_byte;
  logic        r_err;
  logic [15:0] r_byte_count;

  logic        w_start, w_err_evt, w_lat_h, w_lat_l, w_addr_valid, w_cap, w_send;
  logic [15:0] w_addr_rx;

  assign w_addr_rx = {r_addr[15:8], i_rx_byte};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_err_evt    = 1'b0;
    w_lat_h      = 1'b0;
    w_lat_l      = 1'b0;
    w_addr_valid = 1'b0;
    w_cap        = 1'b0;
    w_send       = 1'b0;
    if (i_cs) begin
      // Deselect wins over everything and aborts any pending fetch.
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (r_armed) begin
            w_state_next = StCmd;
            w_start      = 1'b1;
          end
        end
        StCmd: begin
          if (i_rx_valid) begin
            if (i_rx_byte == 8'h03) begin
              w_state_next = StAddrH;
            end else begin
              w_state_next = StErr;
              w_err_evt    = 1'b1;
            end
          end
        end
        StAddrH: begin
          if (i_rx_valid) begin
            w_lat_h      = 1'b1;
            w_state_next = StAddrL;
          end
        end
        StAddrL: begin
          if (i_rx_valid) begin
            w_lat_l = 1'b1;
            if (w_addr_rx <= ADDR_LIMIT) begin
              w_state_next = StFetch;
            end else begin
              w_state_next = StErr;
              w_err_evt    = 1'b1;
            end
          end
        end
        StFetch: begin
          if (i_tx_ready) begin
            w_addr_valid = 1'b1;
            w_state_next = StWait;
          end
        end
        StWait: begin
          w_cap        = 1'b1;
          w_state_next = StSend;
        end
        StSend: begin
          w_send       = 1'b1;
          w_state_next = StHold;
        end
        StHold: begin
          if (!i_tx_ready) w_state_next = StFetch;
        end
        StErr:   w_state_next = StErr;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_armed      <= 1'b0;
      r_addr       <= 16'h0000;
      r_tx_byte    <= 8'h00;
      r_err        <= 1'b0;
      r_byte_count <= 16'h0000;
    end else begin
      if (i_cs) r_armed <= 1'b1;
      r_err <= w_err_evt;
      if (w_start) r_byte_count <= 16'h0000;
      if (w_lat_h) r_addr[15:8] <= i_rx_byte;
      if (w_lat_l) r_addr[7:0]  <= i_rx_byte;
      if (w_cap)   r_tx_byte    <= i_mem_data;
      if (w_send) begin
        r_addr <= (r_addr == ADDR_LIMIT) ? 16'h0000 : r_addr + 16'h0001;
        if (r_byte_count != 16'hFFFF) r_byte_count <= r_byte_count + 16'h0001;
      end
    end
  end

`ifdef BURST_READ_CRC_EN
  logic [7:0] r_crc;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_crc <= 8'h00;
    else if (w_start) r_crc <= 8'h00;
    else if (w_send)  r_crc <= crc8_next(r_crc, r_tx_byte);
  end

  assign o_crc = r_crc;
`else
  assign o_crc = 8'h00;
`endif

  assign o_addr       = r_addr;
  assign o_addr_valid = w_addr_valid;
  assign o_tx_valid   = w_send;
  assign o_tx_byte    = r_tx_byte;
  assign o_busy       = (r_state != StIdle);
  assign o_err        = r_err;
  assign o_byte_count = r_byte_count;

endmodule

// File: tb/tb_burst_read_ctrl.sv
// Directed bench for burst_read_ctrl: command/address parsing, burst reads with
// address wrap, protocol errors, deselect abort, reset mid-burst and CRC.
module tb_burst_read_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_cs, i_rx_valid, i_tx_ready;
  logic [7:0]  i_rx_byte, i_mem_data;
  logic [15:0] o_addr, o_byte_count;
  logic        o_addr_valid, o_tx_valid, o_busy, o_err;
  logic [7:0]  o_tx_byte, o_crc;

  int n_tests = 0;
  int n_fail  = 0;

  burst_read_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cs         (i_cs),
    .i_rx_valid   (i_rx_valid),
    .i_rx_byte    (i_rx_byte),
    .i_tx_ready   (i_tx_ready),
    .i_mem_data   (i_mem_data),
    .o_addr       (o_addr),
    .o_addr_valid (o_addr_valid),
    .o_tx_valid   (o_tx_valid),
    .o_tx_byte    (o_tx_byte),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .o_byte_count (o_byte_count),
    .o_crc        (o_crc)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked there too.
  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    tick();
    i_rx_valid = 1'b0;
    #1;
  endtask

  task automatic start_read(input logic [7:0] ah, input logic [7:0] al);
    i_cs = 1'b0;
    tick();
    send_rx(8'h03);
    send_rx(ah);
    send_rx(al);
  endtask

  // Starts in FETCH, ends back in FETCH after one full byte.
  task automatic do_read(input logic [7:0] data, input logic [15:0] exp_addr,
                         input logic [15:0] exp_cnt);
    i_tx_ready = 1'b1;
    #1;
    check("addr_valid_fetch", o_addr_valid, 1);
    check("addr_fetch", o_addr, exp_addr);
    tick();
    i_mem_data = data;
    #1;
    check("addr_valid_wait", o_addr_valid, 0);
    check("tx_valid_wait", o_tx_valid, 0);
    tick();
    check("tx_valid_send", o_tx_valid, 1);
    check("tx_byte_send", o_tx_byte, data);
    i_tx_ready = 1'b0;
    tick();
    check("tx_valid_hold", o_tx_valid, 0);
    check("byte_count", o_byte_count, exp_cnt);
    check("busy_hold", o_busy, 1);
    tick();
  endtask

  task automatic deselect();
    i_cs       = 1'b1;
    i_tx_ready = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, o_addr, 0);
    check({tag, "_addr_valid"}, o_addr_valid, 0);
    check({tag, "_tx_valid"}, o_tx_valid, 0);
    check({tag, "_tx_byte"}, o_tx_byte, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_count"}, o_byte_count, 0);
    check({tag, "_crc"}, o_crc, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_cs = 1'b1; i_rx_valid = 1'b0; i_rx_byte = 8'h00;
    i_tx_ready = 1'b0; i_mem_data = 8'h00;
    tick();
    tick();
    check_all_zero("reset");
    i_rst = 1'b0;
    tick();

    // Plain burst from 0x0000.
    start_read(8'h00, 8'h00);
    check("busy_fetch", o_busy, 1);
    do_read(8'hA1, 16'h0000, 16'd1);
    do_read(8'hB2, 16'h0001, 16'd2);
    do_read(8'hC3, 16'h0002, 16'd3);
`ifndef BURST_READ_CRC_EN
    check("crc_off", o_crc, 0);
`endif
    deselect();
    check("idle_busy", o_busy, 0);
    check("idle_addr_hold", o_addr, 16'h0003);
    check("idle_count_hold", o_byte_count, 16'd3);

    // Wrap at the last valid address; count clears on a new transaction.
    i_cs = 1'b0;
    tick();
    check("count_clear", o_byte_count, 0);
    send_rx(8'h03);
    send_rx(8'h28);
    send_rx(8'h03);
    do_read(8'hD4, 16'h2803, 16'd1);
    do_read(8'hE5, 16'h0000, 16'd2);
    check("addr_after_wrap", o_addr, 16'h0001);
    deselect();

    // Bad command byte.
    i_cs = 1'b0;
    tick();
    send_rx(8'h05);
    check("err_cmd_pulse", o_err, 1);
    i_tx_ready = 1'b1;
    #1;
    check("err_cmd_no_read", o_addr_valid, 0);
    send_rx(8'h03);
    check("err_cmd_single", o_err, 0);
    check("err_cmd_no_read2", o_addr_valid, 0);
    check("err_cmd_busy", o_busy, 1);
    deselect();
    check("err_cmd_idle", o_busy, 0);

    // Address one past the limit.
    start_read(8'h28, 8'h04);
    check("err_addr_pulse", o_err, 1);
    i_tx_ready = 1'b1;
    tick();
    check("err_addr_single", o_err, 0);
    check("err_addr_no_read", o_addr_valid, 0);
    check("err_addr_no_tx", o_tx_valid, 0);
    deselect();

    // Deselect in FETCH takes priority over tx_ready.
    start_read(8'h00, 8'h10);
    i_cs = 1'b1;
    i_tx_ready = 1'b1;
    #1;
    check("cs_fetch_no_read", o_addr_valid, 0);
    deselect();

    // Deselect during WAIT.
    start_read(8'h00, 8'h10);
    i_tx_ready = 1'b1;
    #1;
    check("abort_fetch_valid", o_addr_valid, 1);
    tick();
    i_cs = 1'b1;
    i_mem_data = 8'h77;
    tick();
    check("abort_no_tx", o_tx_valid, 0);
    check("abort_idle", o_busy, 0);
    tick();
    check("abort_no_tx2", o_tx_valid, 0);
    i_tx_ready = 1'b0;
    tick();

    // Reset mid-burst with cs still low.
    start_read(8'h01, 8'h00);
    do_read(8'h5A, 16'h0100, 16'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_all_zero("rst_mid");
    i_tx_ready = 1'b1;
    send_rx(8'h03);
    send_rx(8'h00);
    check("rst_stay_idle", o_busy, 0);
    check("rst_no_read", o_addr_valid, 0);
    i_tx_ready = 1'b0;
    i_cs = 1'b1;
    tick();
    i_cs = 1'b0;
    tick();
    check("rst_rearm", o_busy, 1);
    deselect();

`ifdef BURST_READ_CRC_EN
    start_read(8'h00, 8'h00);
    do_read(8'h01, 16'h0000, 16'd1);
    check("crc_first", o_crc, 8'h07);
    do_read(8'h02, 16'h0001, 16'd2);
    check("crc_second", o_crc, 8'h1B);
    deselect();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
